// File: rtl/arrow_frame_ctrl.sv
// arrow_frame_ctrl
//   Frame sequencer for the 8-class arrow neuron bank. It collects a 16x16
//   binary image one 16-bit row per handshake into the 256-bit pixel_vector,
//   waits out the bank latency, captures neuron_out and resolves it into a
//   class index presented on a valid/ready result port.
//
// Parameters
//   NEURON_LAT   clock edges from a pixel_vector change to matching neuron_out (1..15)
//   TIMEOUT_CYC  idle-cycle limit between rows of a frame (2..65535); used only
//                when the macro ARROW_CTRL_TIMEOUT_EN is defined
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   row_valid/row_ready  row handshake; row_data bit 15 = leftmost pixel
//   row_sof              marks row 0 of a frame
//   pixel_vector         assembled frame, row 0 in bits [255:240]
//   neuron_out           neuron bank outputs (bit0 UP ... bit7 RIGHT)
//   res_valid/res_ready  result handshake
//   res_class/res_hit/res_multi/res_mask  resolved result fields
//   busy                 controller is not idle
//   err_abort            one-cycle pulse when a partial frame is discarded
//
// Configuration macro: ARROW_CTRL_TIMEOUT_EN (enables the inter-row gap timeout)

module arrow_frame_ctrl #(
  parameter int NEURON_LAT  = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         row_valid,
  output logic         row_ready,
  input  logic [15:0]  row_data,
  input  logic         row_sof,
  output logic [255:0] pixel_vector,
  input  logic [7:0]   neuron_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [2:0]   res_class,
  output logic         res_hit,
  output logic         res_multi,
  output logic [7:0]   res_mask,
  output logic         busy,
  output logic         err_abort
);

  // Elaboration-time guard on the legal parameter ranges.
  if (NEURON_LAT < 1 || NEURON_LAT > 15) begin : g_bad_lat
    $error("arrow_frame_ctrl: NEURON_LAT out of range 1..15");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("arrow_frame_ctrl: TIMEOUT_CYC out of range 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESULT
  } state_t;

  localparam logic [3:0] LAT = 4'(NEURON_LAT);

  state_t     state_reg, state_next;
  logic [3:0] row_cnt_reg, row_cnt_next;
  logic [3:0] lat_cnt_reg, lat_cnt_next;
  logic       err_abort_reg, err_abort_next;
  logic       wr_en;
  logic [3:0] wr_row;
  logic       capture;
  logic       xfer;
  logic       timeout;

  logic [2:0] res_class_reg, class_next;
  logic       res_hit_reg, res_multi_reg;
  logic [7:0] res_mask_reg;

  // Handshake outputs come from registered state only.
  assign row_ready = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  assign busy      = (state_reg != S_IDLE);
  assign res_valid = (state_reg == S_RESULT);
  assign xfer      = row_valid && row_ready;

`ifdef ARROW_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] gap_reg, gap_next;

  // Counts idle cycles between rows while loading; zero outside LOAD so it
  // starts clean on every entry.
  always_comb begin
    gap_next = '0;
    timeout  = 1'b0;
    if (state_reg == S_LOAD && !xfer) begin
      if (gap_reg + 16'd1 == TO_LIM) begin
        timeout = 1'b1;
      end else begin
        gap_next = gap_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_reg <= '0;
    else        gap_reg <= gap_next;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next     = state_reg;
    row_cnt_next   = row_cnt_reg;
    lat_cnt_next   = lat_cnt_reg;
    err_abort_next = 1'b0;
    wr_en          = 1'b0;
    wr_row         = row_cnt_reg;
    capture        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Rows without sof are simply consumed here.
        if (xfer && row_sof) begin
          wr_en        = 1'b1;
          wr_row       = 4'd0;
          row_cnt_next = 4'd1;
          state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (row_sof) begin
            // A new sof mid-frame restarts the frame.
            wr_row         = 4'd0;
            row_cnt_next   = 4'd1;
            err_abort_next = 1'b1;
          end else begin
            row_cnt_next = row_cnt_reg + 4'd1;
            if (row_cnt_reg == 4'd15) begin
              state_next   = S_WAIT;
              lat_cnt_next = 4'd0;
            end
          end
        end else if (timeout) begin
          state_next     = S_IDLE;
          err_abort_next = 1'b1;
        end
      end
      S_WAIT: begin
        lat_cnt_next = lat_cnt_reg + 4'd1;
        if (lat_cnt_reg == LAT) begin
          capture    = 1'b1;
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Lowest set bit wins; scan from the top so the last assignment is lowest.
  always_comb begin
    class_next = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (neuron_out[i]) class_next = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      row_cnt_reg   <= '0;
      lat_cnt_reg   <= '0;
      err_abort_reg <= 1'b0;
      res_class_reg <= '0;
      res_hit_reg   <= 1'b0;
      res_multi_reg <= 1'b0;
      res_mask_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      row_cnt_reg   <= row_cnt_next;
      lat_cnt_reg   <= lat_cnt_next;
      err_abort_reg <= err_abort_next;
      if (capture) begin
        res_mask_reg  <= neuron_out;
        res_class_reg <= class_next;
        res_hit_reg   <= |neuron_out;
        res_multi_reg <= ($countones(neuron_out) > 1);
      end
    end
  end

  // One register per image row; row k sits at pixel_vector[255-16k -: 16].
  for (genvar gi = 0; gi < 16; gi++) begin : g_row
    logic [15:0] row_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             row_reg <= '0;
      else if (wr_en && (wr_row == 4'(gi)))   row_reg <= row_data;
    end
    assign pixel_vector[255-16*gi -: 16] = row_reg;
  end

  assign err_abort = err_abort_reg;
  assign res_class = res_class_reg;
  assign res_hit   = res_hit_reg;
  assign res_multi = res_multi_reg;
  assign res_mask  = res_mask_reg;

endmodule

// File: tb/tb_arrow_frame_ctrl.sv
// Self-checking bench for arrow_frame_ctrl. A latency-accurate neuron bank
// stub returns the chosen value only once pixel_vector holds the expected
// frame; results are checked against a frame/class model in the bench.
module tb_arrow_frame_ctrl;
  localparam int NL = 1;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         row_valid, row_ready, row_sof;
  logic [15:0]  row_data;
  logic [255:0] pixel_vector;
  logic [7:0]   neuron_out;
  logic         res_valid, res_ready, res_hit, res_multi, busy, err_abort;
  logic [2:0]   res_class;
  logic [7:0]   res_mask;

  int tests = 0;
  int fails = 0;

  logic [15:0]  fr [16];
  logic [255:0] model_pv;
  logic [255:0] stub_pv;
  logic [7:0]   stub_val;
  logic [7:0]   lat_pipe [NL];

  arrow_frame_ctrl #(.NEURON_LAT(NL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_sof(row_sof),
    .pixel_vector(pixel_vector), .neuron_out(neuron_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_hit(res_hit), .res_multi(res_multi), .res_mask(res_mask),
    .busy(busy), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  // Bank stub: NL-edge registered latency; garbage unless the frame matches.
  always @(posedge clk) begin
    lat_pipe[0] <= (pixel_vector === stub_pv) ? stub_val : ~stub_val;
    for (int i = 1; i < NL; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign neuron_out = lat_pipe[NL-1];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] frame_pv();
    logic [255:0] v = '0;
    for (int k = 0; k < 16; k++) v[255-16*k -: 16] = fr[k];
    return v;
  endfunction

  function automatic logic [2:0] exp_class(input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) return 3'(b);
    return 3'd0;
  endfunction

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) fr[k] = 16'($urandom);
  endtask

  task automatic send_row(input logic [15:0] d, input logic sof, input logic exp_abort);
    int w = 0;
    while (!row_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!row_ready) begin
      tests++; fails++;
      $display("FAIL row_ready_wait: got row_ready=%b want 1", row_ready);
    end
    row_valid = 1'b1; row_data = d; row_sof = sof;
    @(posedge clk); #1;
    row_valid = 1'b0; row_sof = 1'b0;
    tests++;
    if (err_abort !== exp_abort) begin
      fails++; $display("FAIL err_abort_row: got %b want %b", err_abort, exp_abort);
    end
    $display("[TB] row %h sof=%b err_abort=%b", d, sof, err_abort);
  endtask

  // Called just after the row-15 transfer edge E0.
  task automatic expect_result();
    tests++;
    if (row_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL wait_state: got row_ready=%b busy=%b want 0 1", row_ready, busy);
    end
    for (int t = 1; t <= NL + 1; t++) begin
      @(posedge clk); #1;
      tests++;
      if (res_valid !== (t == NL + 1)) begin
        fails++; $display("FAIL res_valid_timing: edge E0+%0d got %b want %b", t, res_valid, (t == NL + 1));
      end
    end
    tests++;
    if (pixel_vector !== frame_pv()) begin
      fails++; $display("FAIL pixel_vector: got %h want %h", pixel_vector, frame_pv());
    end
    tests++;
    if (res_mask !== stub_val || res_class !== exp_class(stub_val) ||
        res_hit !== (stub_val != 8'h00) || res_multi !== ($countones(stub_val) >= 2)) begin
      fails++;
      $display("FAIL result: got mask=%h class=%0d hit=%b multi=%b want mask=%h class=%0d hit=%b multi=%b",
               res_mask, res_class, res_hit, res_multi, stub_val, exp_class(stub_val),
               (stub_val != 8'h00), ($countones(stub_val) >= 2));
    end
    $display("[TB] result mask=%h class=%0d hit=%b multi=%b", res_mask, res_class, res_hit, res_multi);
  endtask

  task automatic load_frame(input logic [7:0] stub, input logic abort_first);
    stub_pv = frame_pv(); stub_val = stub;
    for (int k = 0; k < 16; k++) send_row(fr[k], (k == 0), (k == 0) && abort_first);
    expect_result();
    model_pv = stub_pv;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || row_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL accept: got valid=%b ready=%b busy=%b want 0 1 0", res_valid, row_ready, busy);
    end
    $display("[TB] accept valid=%b row_ready=%b busy=%b", res_valid, row_ready, busy);
  endtask

  task automatic test_reset();
    tests++;
    if (row_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || err_abort !== 1'b0 ||
        pixel_vector !== 256'd0 || res_mask !== 8'd0 || res_class !== 3'd0 ||
        res_hit !== 1'b0 || res_multi !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got ready=%b busy=%b valid=%b abort=%b pv=%h mask=%h want 1 0 0 0 0 0",
               row_ready, busy, res_valid, err_abort, pixel_vector, res_mask);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (row_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset: got ready=%b busy=%b want 1 0", row_ready, busy);
    end
    $display("[TB] reset ready=%b busy=%b", row_ready, busy);
  endtask

  task automatic test_basic_frame();
    for (int k = 0; k < 16; k++) fr[k] = 16'h0000;
    fr[2] = 16'h0100; fr[3] = 16'h0380; fr[4] = 16'h07C0;
    load_frame(8'h01, 1'b0);
    tests++;
    if (pixel_vector[223:208] !== 16'h0100) begin
      fails++; $display("FAIL row2_slot: got %h want 0100", pixel_vector[223:208]);
    end
    accept();
  endtask

  task automatic test_resolution();
    logic [7:0] stubs [5] = '{8'h28, 8'h00, 8'h80, 8'hFF, 8'h01};
    for (int i = 0; i < 5; i++) begin rand_frame(); load_frame(stubs[i], 1'b0); accept(); end
    for (int i = 0; i < 8; i++) begin rand_frame(); load_frame(8'($urandom), 1'b0); accept(); end
  endtask

  task automatic test_backpressure();
    rand_frame();
    load_frame(8'($urandom), 1'b0);
    row_valid = 1'b1; row_sof = 1'b0; row_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (row_ready !== 1'b0 || res_valid !== 1'b1 || res_mask !== stub_val ||
          res_class !== exp_class(stub_val) || pixel_vector !== model_pv) begin
        fails++;
        $display("FAIL hold: got ready=%b valid=%b mask=%h class=%0d want 0 1 %h %0d",
                 row_ready, res_valid, res_mask, res_class, stub_val, exp_class(stub_val));
      end
      $display("[TB] hold cycle %0d valid=%b mask=%h", i, res_valid, res_mask);
    end
    accept();
    @(posedge clk); #1;
    row_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || pixel_vector !== model_pv) begin
      fails++; $display("FAIL after_hold: got busy=%b pv=%h want 0 %h", busy, pixel_vector, model_pv);
    end
  endtask

  task automatic test_restart();
    rand_frame();
    for (int k = 0; k < 7; k++) send_row(fr[k], (k == 0), 1'b0);
    rand_frame();
    load_frame(8'($urandom), 1'b1);
    accept();
  endtask

  task automatic test_idle_discard();
    for (int i = 0; i < 4; i++) begin
      send_row(16'($urandom), 1'b0, 1'b0);
      tests++;
      if (busy !== 1'b0 || pixel_vector !== model_pv) begin
        fails++; $display("FAIL idle_discard: got busy=%b pv=%h want 0 %h", busy, pixel_vector, model_pv);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    rand_frame();
    stub_pv = frame_pv(); stub_val = 8'h10;
    for (int k = 0; k < 16; k++) send_row(fr[k], (k == 0), 1'b0);
    rst_n = 1'b0;
    #1;
    tests++;
    if (res_valid !== 1'b0 || pixel_vector !== 256'd0 || busy !== 1'b0 ||
        err_abort !== 1'b0 || row_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_wait: got valid=%b pv=%h busy=%b abort=%b ready=%b want 0 0 0 0 1",
               res_valid, pixel_vector, busy, err_abort, row_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    model_pv = '0;
    for (int i = 0; i < NL + 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (res_valid !== 1'b0 || res_mask !== 8'd0 || busy !== 1'b0) begin
        fails++; $display("FAIL no_capture: got valid=%b mask=%h busy=%b want 0 00 0", res_valid, res_mask, busy);
      end
    end
    $display("[TB] reset in WAIT valid=%b pv_zero=%b", res_valid, (pixel_vector == 256'd0));
  endtask

  task automatic test_stall();
    rand_frame();
    for (int k = 0; k < 5; k++) begin
      send_row(fr[k], (k == 0), 1'b0);
      model_pv[255-16*k -: 16] = fr[k];
    end
`ifdef ARROW_CTRL_TIMEOUT_EN
    begin
      int seen = -1;
      for (int i = 1; i <= TO + 5 && seen < 0; i++) begin
        @(posedge clk); #1;
        if (err_abort === 1'b1) seen = i;
      end
      tests++;
      if (seen != TO || busy !== 1'b0 || row_ready !== 1'b1) begin
        fails++; $display("FAIL timeout: got abort at %0d busy=%b want %0d 0", seen, busy, TO);
      end
      @(posedge clk); #1;
      tests++;
      if (err_abort !== 1'b0 || pixel_vector !== model_pv) begin
        fails++; $display("FAIL timeout_pulse: got abort=%b pv=%h want 0 %h", err_abort, pixel_vector, model_pv);
      end
      $display("[TB] timeout abort at idle cycle %0d", seen);
    end
`else
    begin
      int aborts = 0;
      int drops = 0;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk); #1;
        if (err_abort === 1'b1) aborts++;
        if (busy !== 1'b1) drops++;
      end
      tests++;
      if (aborts != 0 || drops != 0 || row_ready !== 1'b1) begin
        fails++; $display("FAIL stall: got aborts=%0d not_busy=%0d want 0 0", aborts, drops);
      end
      $display("[TB] stall 1000 cycles aborts=%0d busy=%b", aborts, busy);
      stub_pv = frame_pv(); stub_val = 8'h44;
      for (int k = 5; k < 16; k++) send_row(fr[k], 1'b0, 1'b0);
      expect_result();
      model_pv = stub_pv;
      accept();
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; row_valid = 1'b0; row_sof = 1'b0; row_data = '0; res_ready = 1'b0;
    stub_pv = '0; stub_val = 8'h00; model_pv = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic_frame();
    test_resolution();
    test_backpressure();
    test_restart();
    test_idle_discard();
    test_reset_in_wait();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
